// File: rtl/retire_trace_fifo.sv
// Retire trace buffer: captures one record per retired instruction
// and hands them to a consumer over a valid/ready handshake.
module retire_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             retire_valid_i,
  input  logic [31:0]      retire_pc_i,
  input  logic [31:0]      retire_instr_i,
  input  logic             rf_we_i,
  input  logic [4:0]       rf_waddr_i,
  input  logic [31:0]      rf_wdata_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_wdata_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [SEQ_W-1:0] trace_seq_o,
  output logic [31:0]      trace_pc_o,
  output logic [31:0]      trace_instr_o,
  output logic             trace_rf_we_o,
  output logic [4:0]       trace_rf_waddr_o,
  output logic [31:0]      trace_rf_wdata_o,
  output logic             trace_mem_we_o,
  output logic [31:0]      trace_mem_addr_o,
  output logic [31:0]      trace_mem_wdata_o,
  output logic             halted_o,
  output logic             overflow_o,
  output logic [SEQ_W-1:0] retire_cnt_o,
  output logic [SEQ_W-1:0] drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] rcnt_q, rcnt_d;
  logic [SEQ_W-1:0] dcnt_q, dcnt_d;
  logic             halted_q, halted_d;
  logic             ovf_q, ovf_d;

  logic ev, full, pop, push, drop;
  rec_t wr_rec, head;

  always_comb begin
    ev   = retire_valid_i & ~halted_q;
    full = (cnt_q == CW'(DEPTH));
    pop  = (cnt_q != '0) & trace_ready_i;
    push = ev & (~full | pop);
    drop = ev & ~push;

    wr_rec.seq       = seq_q;
    wr_rec.pc        = retire_pc_i;
    wr_rec.instr     = retire_instr_i;
    // x0 is hardwired; a write to it is not architectural
    wr_rec.rf_we     = rf_we_i & (rf_waddr_i != 5'd0);
    wr_rec.rf_waddr  = rf_waddr_i;
    wr_rec.rf_wdata  = rf_wdata_i;
    wr_rec.mem_we    = mem_we_i;
    wr_rec.mem_addr  = mem_addr_i;
    wr_rec.mem_wdata = mem_wdata_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    rcnt_d   = rcnt_q;
    dcnt_d   = dcnt_q;
    halted_d = halted_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    if (ev) begin
      seq_d  = seq_q + SEQ_W'(1);
      rcnt_d = rcnt_q + SEQ_W'(1);
      if (retire_instr_i == 32'h0) halted_d = 1'b1;
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (dcnt_q != '1) dcnt_d = dcnt_q + SEQ_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
      rcnt_q   <= '0;
      dcnt_q   <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      rcnt_q   <= rcnt_d;
      dcnt_q   <= dcnt_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
    end
  end

  // storage is left unreset; outputs are masked while empty
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_comb begin
    trace_valid_o = (cnt_q != '0);
    head = trace_valid_o ? mem_q[rd_ptr_q] : '0;
  end

  assign trace_seq_o       = head.seq;
  assign trace_pc_o        = head.pc;
  assign trace_instr_o     = head.instr;
  assign trace_rf_we_o     = head.rf_we;
  assign trace_rf_waddr_o  = head.rf_waddr;
  assign trace_rf_wdata_o  = head.rf_wdata;
  assign trace_mem_we_o    = head.mem_we;
  assign trace_mem_addr_o  = head.mem_addr;
  assign trace_mem_wdata_o = head.mem_wdata;
  assign halted_o          = halted_q;
  assign overflow_o        = ovf_q;
  assign retire_cnt_o      = rcnt_q;
  assign drop_cnt_o        = dcnt_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Scoreboard bench for retire_trace_fifo: expected records are queued
// when a retire is driven and compared at the head every cycle.
module tb_retire_trace_fifo;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 16;
  localparam int RW = SEQ_W + 32 + 32 + 1 + 5 + 32 + 1 + 32 + 32;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             retire_valid_i = 1'b0;
  logic [31:0]      retire_pc_i = '0;
  logic [31:0]      retire_instr_i = '0;
  logic             rf_we_i = 1'b0;
  logic [4:0]       rf_waddr_i = '0;
  logic [31:0]      rf_wdata_i = '0;
  logic             mem_we_i = 1'b0;
  logic [31:0]      mem_addr_i = '0;
  logic [31:0]      mem_wdata_i = '0;
  logic             trace_valid_o;
  logic             trace_ready_i = 1'b0;
  logic [SEQ_W-1:0] trace_seq_o;
  logic [31:0]      trace_pc_o;
  logic [31:0]      trace_instr_o;
  logic             trace_rf_we_o;
  logic [4:0]       trace_rf_waddr_o;
  logic [31:0]      trace_rf_wdata_o;
  logic             trace_mem_we_o;
  logic [31:0]      trace_mem_addr_o;
  logic [31:0]      trace_mem_wdata_o;
  logic             halted_o;
  logic             overflow_o;
  logic [SEQ_W-1:0] retire_cnt_o;
  logic [SEQ_W-1:0] drop_cnt_o;

  retire_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .retire_valid_i(retire_valid_i),
    .retire_pc_i(retire_pc_i),
    .retire_instr_i(retire_instr_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .rf_wdata_i(rf_wdata_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .trace_valid_o(trace_valid_o),
    .trace_ready_i(trace_ready_i),
    .trace_seq_o(trace_seq_o),
    .trace_pc_o(trace_pc_o),
    .trace_instr_o(trace_instr_o),
    .trace_rf_we_o(trace_rf_we_o),
    .trace_rf_waddr_o(trace_rf_waddr_o),
    .trace_rf_wdata_o(trace_rf_wdata_o),
    .trace_mem_we_o(trace_mem_we_o),
    .trace_mem_addr_o(trace_mem_addr_o),
    .trace_mem_wdata_o(trace_mem_wdata_o),
    .halted_o(halted_o), .overflow_o(overflow_o),
    .retire_cnt_o(retire_cnt_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int n_halt_rec = 0;

  logic [RW-1:0]    m_q [$];
  logic [SEQ_W-1:0] m_seq, m_rcnt, m_dcnt;
  logic             m_halt, m_ovf;

  task automatic chk(input string tag,
                     input logic [191:0] got,
                     input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] dut_head();
    return {trace_seq_o, trace_pc_o, trace_instr_o,
            trace_rf_we_o, trace_rf_waddr_o, trace_rf_wdata_o,
            trace_mem_we_o, trace_mem_addr_o, trace_mem_wdata_o};
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_seq = '0; m_rcnt = '0; m_dcnt = '0;
    m_halt = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic chk_state();
    chk("valid", trace_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) chk("head", dut_head(), m_q[0]);
    else chk("head0", dut_head(), '0);
    chk("rcnt", retire_cnt_o, m_rcnt);
    chk("dcnt", drop_cnt_o, m_dcnt);
    chk("halt", halted_o, m_halt);
    chk("ovf", overflow_o, m_ovf);
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic [31:0] ins, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic mwe, input logic [31:0] ma,
                     input logic [31:0] md, input logic rdy);
    logic ev;
    @(negedge clk_i);
    chk_state();
    if (trace_valid_o && rdy && trace_instr_o == 32'h0)
      n_halt_rec++;
    retire_valid_i = v; retire_pc_i = pc;
    retire_instr_i = ins; rf_we_i = we;
    rf_waddr_i = wa; rf_wdata_i = wd;
    mem_we_i = mwe; mem_addr_i = ma;
    mem_wdata_i = md; trace_ready_i = rdy;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    ev = v && !m_halt;
    if (ev) begin
      if (m_q.size() < DEPTH)
        m_q.push_back({m_seq, pc, ins, we && (wa != 5'd0),
                       wa, wd, mwe, ma, md});
      else begin
        m_ovf = 1'b1;
        if (m_dcnt != '1) m_dcnt++;
      end
      m_seq++;
      m_rcnt++;
      if (ins == 32'h0) m_halt = 1'b1;
    end
    @(posedge clk_i);
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic ret(input logic [31:0] pc, input logic [31:0] ins,
                     input logic rdy);
    cyc(1, pc, ins, 1, ins[4:0], pc + 32'h100, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n = 1'b0;
    retire_valid_i = 1'b0;
    trace_ready_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    do_reset();
    chk_state();

    // single retire, consumer always ready
    cyc(1, 32'h0, 32'h20010005, 1, 5'd1, 32'd5, 0, 0, 0, 1);
    idle(1);
    idle(1);

    // ten retires into a stalled FIFO: two drops
    do_reset();
    for (int i = 0; i < 10; i++) ret(32'h40 + 4 * i, 32'h1000 + i, 0);
    idle(0);
    idle(0);
    chk("drop2", drop_cnt_o, 16'd2);
    for (int i = 0; i < 9; i++) idle(1);
    ret(32'h400, 32'h2222, 1);
    idle(1);
    chk("seq10_drained", m_q.size(), 0);

    // full FIFO: push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) ret(32'h80 + 4 * i, 32'h3000 + i, 0);
    ret(32'hA0, 32'h3333, 1);
    idle(0);
    chk("full_nodrop", drop_cnt_o, 16'd0);
    ret(32'hA4, 32'h4444, 0);
    for (int i = 0; i < 10; i++) idle(1);

    // store and x0 write
    do_reset();
    cyc(1, 32'h18, 32'hAC220004, 0, 5'd0, 32'd0,
        1, 32'h84, 32'h12345678, 1);
    cyc(1, 32'h1C, 32'h20000007, 1, 5'd0, 32'd7, 0, 0, 0, 1);
    cyc(1, 32'h20, 32'h2003FFFF, 1, 5'd31, 32'hFFFF_FFFF, 0, 0, 0, 0);
    idle(0);
    idle(1);
    idle(1);
    idle(1);

    // halt then three ignored retires
    do_reset();
    n_halt_rec = 0;
    ret(32'h28, 32'h5555, 1);
    ret(32'h2C, 32'h0, 1);
    ret(32'h30, 32'h6666, 1);
    ret(32'h34, 32'h0, 1);
    ret(32'h38, 32'h7777, 1);
    idle(1);
    idle(1);
    chk("halt_recs", n_halt_rec, 1);
    chk("halt_rcnt", retire_cnt_o, 16'd2);

    // async reset with records buffered
    do_reset();
    for (int i = 0; i < 5; i++) ret(32'h200 + 4 * i, 32'h8000 + i, 0);
    idle(0);
    @(negedge clk_i);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    chk_state();
    @(negedge clk_i);
    rst_n = 1'b1;
    idle(1);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Downstream observer of Simple_Single_CPU.
- Captures one record per retired instruction: PC, instruction word, register-file write, data-memory write. Buffers records in a FIFO.
- The bench or result-file writer drains records through a valid/ready handshake, so architectural state can be compared per instruction instead of by peeking into hierarchy.
- Detects the all-zero halt instruction, stops capture, and counts retires and drops.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2
SEQ_W, 16, width of retire sequence number and counters

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
retire_valid_i  input  1  one instruction retires this cycle
retire_pc_i  input  32  PC of the retiring instruction
retire_instr_i  input  32  instruction word
rf_we_i  input  1  register-file write enable
rf_waddr_i  input  5  destination register
rf_wdata_i  input  32  write data
mem_we_i  input  1  data-memory write enable
mem_addr_i  input  32  byte address of the store
mem_wdata_i  input  32  store data
trace_valid_o  output  1  head record available
trace_ready_i  input  1  consumer accepts the head record
trace_seq_o  output  SEQ_W  sequence number of the head record
trace_pc_o  output  32  head record PC
trace_instr_o  output  32  head record instruction
trace_rf_we_o  output  1  head record register write
trace_rf_waddr_o  output  5  head record destination register
trace_rf_wdata_o  output  32  head record write data
trace_mem_we_o  output  1  head record store
trace_mem_addr_o  output  32  head record store address
trace_mem_wdata_o  output  32  head record store data
halted_o  output  1  sticky; halt instruction seen
overflow_o  output  1  sticky; at least one record dropped
retire_cnt_o  output  SEQ_W  retires observed, including dropped ones
drop_cnt_o  output  SEQ_W  records dropped

Behaviour:
Reset:
- rst_n low clears, asynchronously: write/read pointers, occupancy, seq counter, retire_cnt_o, drop_cnt_o, halted_o, overflow_o.
- trace_valid_o = 0. All trace_*_o fields = 0; FIFO storage is not cleared.
- Reset asserted mid-transfer discards all buffered records.

Capture:
- A retire event is retire_valid_i=1 and halted_o=0.
- Each event takes seq = current seq counter. seq counter and retire_cnt_o each increment by 1 and wrap modulo 2^SEQ_W.
- The record is pushed if not full, or if full and a pop occurs in the same cycle (occupancy unchanged, oldest entry leaves, new entry enters).
- Otherwise the record is dropped: drop_cnt_o increments (saturating at all-ones) and overflow_o sets. A dropped record still consumes its seq, so the consumer sees a gap.
- Register 0: rf_we_i=1 with rf_waddr_i=0 is recorded with rf_we=0; waddr and wdata are recorded unchanged.
- When halted_o=1, retire_valid_i is ignored: no push, no counter change.

Halt:
- retire_instr_i == 32'h0 on a retire event is recorded normally as the final record.
- halted_o sets on the same edge. Only reset clears it.

Drain:
- trace_valid_o = occupancy != 0; trace_*_o show the head entry.
- A pop happens on an edge where trace_valid_o=1 and trace_ready_i=1.
- The consumer may hold trace_ready_i high continuously.
- There is no fall-through: a record pushed into an empty FIFO is visible on trace_valid_o one cycle after the capture edge (registered occupancy).
- While trace_valid_o=1 and trace_ready_i=0, all trace_*_o stay stable.
- trace_ready_i with trace_valid_o=0 is ignored.

Pointers and ordering:
- Pointers are log2(DEPTH) bits and wrap naturally. A separate occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- Records come out in retire order with no duplication.

Test Plan:
- Reset, then retire pc=0 instr=0x20010005 rf_we=1 waddr=1 wdata=5 with ready=1 → trace_valid_o=1 one cycle later with seq=0, pc=0, rf_waddr=1, rf_wdata=5; popped on that edge; retire_cnt_o=1.
- ready=0, retire 10 consecutive instructions, DEPTH=8 → 8 records held with seq 0..7; drop_cnt_o=2, overflow_o=1, retire_cnt_o=10. Then ready=1 → seq 0..7 drained in order; the next accepted retire carries seq=10.
- FIFO full, retire and pop in the same cycle → occupancy stays 8, no drop, the new record appears last.
- Store pc=0x18 instr=0xAC220004 mem_we=1 addr=0x84 wdata=0x12345678 → record has mem_we=1, addr=0x84, wdata=0x12345678, rf_we=0.
- Retire with rf_we=1, waddr=0, wdata=7 → record has rf_we=0, waddr=0, wdata=7.
- Retire instr=0 at pc=0x2C, then 3 more retires → halted_o=1 from the next cycle; exactly one record with instr=0 is delivered; retire_cnt_o unchanged by the later 3.
- Assert rst_n=0 asynchronously with 5 records buffered and ready=0 → trace_valid_o=0, counters 0 and flags 0 immediately, before the next clock edge.
